// File: rtl/motion_sched_pkg.sv
// Shared types and constants for the move timing scheduler: axis/phase counts,
// FSM state encoding and the packed per-phase timing vector.
package motion_sched_pkg;

  localparam int AXES     = 4;
  localparam int PHASES   = 4;
  localparam int TIMING_W = 64;

  localparam int AX_A = 0;
  localparam int AX_B = 1;
  localparam int AX_Z = 2;
  localparam int AX_E = 3;

  localparam logic [AXES-1:0] ALL_AXES_DONE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    MAX  = 2'd2,
    HOLD = 2'd3
  } sched_state_t;

  // Element [i] is phase i.
  typedef logic [PHASES-1:0][TIMING_W-1:0] timing_vec_t;

endpackage

// File: rtl/move_timing_scheduler_watchdog.sv
// Wait-phase watchdog: counts cycles while enabled, restarts on clear, and
// flags expiry once the count reaches LIMIT-1.
module sched_watchdog #(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expired = enable && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/move_timing_scheduler.sv
// Sequences one motion segment: axis calculators -> max-timing unit -> step stage.
// Optional per-phase watchdog enabled by defining SCHED_TIMEOUT_EN.
module move_timing_scheduler
  import motion_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ID_W           = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_W-1:0]     cmd_id,
  output logic                calc_start,
  input  logic [AXES-1:0]     calc_done,
  output logic                max_start,
  input  logic                max_finish,
  input  timing_vec_t         max_timing,
  output logic                seg_valid,
  input  logic                seg_ready,
  output timing_vec_t         seg_timing,
  output logic [TIMING_W-1:0] seg_total,
  output logic [ID_W-1:0]     seg_id,
  output logic                busy,
  output logic                timeout_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  // Sum in two extra bits so four full-scale phases cannot wrap before clamping.
  function automatic logic [TIMING_W-1:0] sat_total(input timing_vec_t t);
    logic [TIMING_W+1:0] acc;
    acc = '0;
    for (int i = 0; i < PHASES; i++) begin
      acc = acc + {2'b00, t[i]};
    end
    sat_total = (|acc[TIMING_W+1:TIMING_W]) ? '1 : acc[TIMING_W-1:0];
  endfunction

  sched_state_t          state_q;
  logic [AXES-1:0]       mask_q, mask_d;
  logic                  cmd_ready_q, calc_start_q, max_start_q;
  logic                  seg_valid_q, busy_q;
  timing_vec_t           seg_timing_q;
  logic [TIMING_W-1:0]   seg_total_q;
  logic [ID_W-1:0]       seg_id_q;
  logic                  cmd_fire, calc_complete, wd_expire;

  // Done bits seen in the calc_start cycle belong to a previous move.
  assign mask_d        = calc_start_q ? mask_q : (mask_q | calc_done);
  assign cmd_fire      = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign calc_complete = (state_q == CALC) && (mask_d == ALL_AXES_DONE);

`ifdef SCHED_TIMEOUT_EN
  logic timeout_q;
  logic wd_clear, wd_en;

  assign wd_clear = cmd_fire || calc_complete;
  assign wd_en    = (state_q == CALC) || (state_q == MAX);

  sched_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expire)
  );

  assign timeout_err = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      cmd_ready_q  <= 1'b0;
      calc_start_q <= 1'b0;
      max_start_q  <= 1'b0;
      seg_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      seg_timing_q <= '0;
      seg_total_q  <= '0;
      seg_id_q     <= '0;
`ifdef SCHED_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      calc_start_q <= 1'b0;
      max_start_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            seg_id_q     <= cmd_id;
            mask_q       <= '0;
            calc_start_q <= 1'b1;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= CALC;
`ifdef SCHED_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
          end
        end
        CALC: begin
          mask_q <= mask_d;
          if (calc_complete) begin
            max_start_q <= 1'b1;
            state_q     <= MAX;
          end else if (wd_expire) begin
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
`ifdef SCHED_TIMEOUT_EN
            timeout_q   <= 1'b1;
`endif
          end
        end
        MAX: begin
          if (max_finish) begin
            seg_timing_q <= max_timing;
            seg_total_q  <= sat_total(max_timing);
            seg_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end else if (wd_expire) begin
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
`ifdef SCHED_TIMEOUT_EN
            timeout_q   <= 1'b1;
`endif
          end
        end
        HOLD: begin
          if (seg_ready) begin
            seg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign calc_start = calc_start_q;
  assign max_start  = max_start_q;
  assign seg_valid  = seg_valid_q;
  assign seg_timing = seg_timing_q;
  assign seg_total  = seg_total_q;
  assign seg_id     = seg_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_move_timing_scheduler.sv
// Directed self-checking bench for move_timing_scheduler; inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_move_timing_scheduler;
  import motion_sched_pkg::*;

  localparam int ID_W = 8;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid, cmd_ready;
  logic [ID_W-1:0]   cmd_id;
  logic              calc_start;
  logic [AXES-1:0]   calc_done;
  logic              max_start, max_finish;
  timing_vec_t       max_timing, seg_timing;
  logic              seg_valid, seg_ready;
  logic [63:0]       seg_total;
  logic [ID_W-1:0]   seg_id;
  logic              busy, timeout_err;

  int n_eval = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  move_timing_scheduler #(
    .TIMEOUT_CYCLES (16),
    .ID_W           (ID_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_id      (cmd_id),
    .calc_start  (calc_start),
    .calc_done   (calc_done),
    .max_start   (max_start),
    .max_finish  (max_finish),
    .max_timing  (max_timing),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .seg_timing  (seg_timing),
    .seg_total   (seg_total),
    .seg_id      (seg_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid  = 1'b0;
    calc_done  = '0;
    max_finish = 1'b0;
    seg_ready  = 1'b0;
  endtask

  task automatic set_timing(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic [63:0] d);
    max_timing[0] = a;
    max_timing[1] = b;
    max_timing[2] = c;
    max_timing[3] = d;
  endtask

  // Accept a command and complete all axes at cycle 2; returns in the max_start cycle.
  task automatic start_move(input logic [ID_W-1:0] id);
    cmd_valid = 1'b1; cmd_id = id; tick();
    cmd_valid = 1'b0; tick();
    calc_done = 4'b1111; tick();
    calc_done = 4'b0000;
  endtask

  // Pulse max_finish one cycle after max_start; returns in the first seg_valid cycle.
  task automatic finish_max(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic [63:0] d);
    tick();
    max_finish = 1'b1; set_timing(a, b, c, d); tick();
    max_finish = 1'b0;
  endtask

  task automatic handshake();
    seg_ready = 1'b1; tick();
    seg_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs(); cmd_id = '0; set_timing(0, 0, 0, 0);
    reset = 1'b0;
    tick(); tick();
    n_eval++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_eval++; if ({calc_start, max_start, seg_valid, busy, timeout_err} !== 5'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b want 00000", {calc_start, max_start, seg_valid, busy, timeout_err}); end
    n_eval++; if (seg_total !== 64'd0 || seg_id !== '0 || seg_timing !== '0) begin n_fail++; $display("FAIL rst_data: total %h id %h", seg_total, seg_id); end
    reset = 1'b1;
    n_eval++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready: got %b want 0", cmd_ready); end
    tick();
    n_eval++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_first_cycle: ready %b busy %b want 1 0", cmd_ready, busy); end
  endtask

  task automatic test_basic_flow();
    n_eval++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_c0: got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_id = 8'h5A; tick();
    cmd_valid = 1'b0;
    n_eval++; if ({calc_start, cmd_ready, busy} !== 3'b101) begin n_fail++; $display("FAIL basic_c1: start/ready/busy %b want 101", {calc_start, cmd_ready, busy}); end
    tick();
    n_eval++; if (calc_start !== 1'b0) begin n_fail++; $display("FAIL basic_start_pulse: got %b want 0", calc_start); end
    calc_done = 4'b0001; tick();
    calc_done = 4'b0110; tick();
    calc_done = 4'b0000;
    n_eval++; if (max_start !== 1'b0) begin n_fail++; $display("FAIL basic_early_max_start: got %b want 0", max_start); end
    tick();
    calc_done = 4'b1000; tick();
    calc_done = 4'b0000;
    n_eval++; if (max_start !== 1'b1) begin n_fail++; $display("FAIL basic_max_start_c6: got %b want 1", max_start); end
    tick();
    n_eval++; if (max_start !== 1'b0) begin n_fail++; $display("FAIL basic_max_start_pulse: got %b want 0", max_start); end
    tick();
    n_eval++; if (seg_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", seg_valid); end
    max_finish = 1'b1; set_timing(10, 20, 30, 40); tick();
    max_finish = 1'b0;
    n_eval++; if (seg_valid !== 1'b1 || seg_total !== 64'd100 || seg_id !== 8'h5A) begin n_fail++; $display("FAIL basic_seg_c9: valid %b total %0d id %h want 1 100 5a", seg_valid, seg_total, seg_id); end
    n_eval++; if (seg_timing[0] !== 64'd10 || seg_timing[3] !== 64'd40) begin n_fail++; $display("FAIL basic_seg_timing: p0 %0d p3 %0d want 10 40", seg_timing[0], seg_timing[3]); end
    handshake();
    n_eval++; if ({seg_valid, cmd_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL basic_after_hs: valid/ready/busy %b want 010", {seg_valid, cmd_ready, busy}); end
  endtask

  task automatic test_stale_done();
    cmd_valid = 1'b1; cmd_id = 8'h11; tick();
    cmd_valid = 1'b0; calc_done = 4'b1111; tick();
    calc_done = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      n_eval++; if (max_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stale_stays_calc[%0d]: max_start %b busy %b want 0 1", i, max_start, busy); end
      tick();
    end
    calc_done = 4'b1111; tick();
    calc_done = 4'b0000;
    n_eval++; if (max_start !== 1'b1) begin n_fail++; $display("FAIL stale_completes: max_start %b want 1", max_start); end
    finish_max(1, 2, 3, 4);
    n_eval++; if (seg_total !== 64'd10 || seg_id !== 8'h11) begin n_fail++; $display("FAIL stale_seg: total %0d id %h want 10 11", seg_total, seg_id); end
    handshake();
  endtask

  task automatic test_ignored_inputs();
    calc_done = 4'b1111; max_finish = 1'b1; set_timing(5, 5, 5, 5); tick(); tick();
    calc_done = 4'b0000; max_finish = 1'b0;
    n_eval++; if (busy !== 1'b0 || seg_valid !== 1'b0 || max_start !== 1'b0) begin n_fail++; $display("FAIL ign_idle: busy %b valid %b max_start %b want 0 0 0", busy, seg_valid, max_start); end
    cmd_valid = 1'b1; cmd_id = 8'h22; tick();
    cmd_valid = 1'b0; tick();
    calc_done = 4'b0001; tick();
    calc_done = 4'b0001; max_finish = 1'b1; set_timing(7, 7, 7, 7); tick();
    calc_done = 4'b0110; max_finish = 1'b0; tick();
    calc_done = 4'b1000;
    n_eval++; if (max_start !== 1'b0) begin n_fail++; $display("FAIL ign_repeat_bit: max_start %b want 0", max_start); end
    tick();
    calc_done = 4'b0000;
    n_eval++; if (max_start !== 1'b1 || seg_valid !== 1'b0) begin n_fail++; $display("FAIL ign_max_start: max_start %b valid %b want 1 0", max_start, seg_valid); end
    finish_max(100, 200, 300, 400);
    n_eval++; if (seg_total !== 64'd1000 || seg_id !== 8'h22) begin n_fail++; $display("FAIL ign_seg: total %0d id %h want 1000 22", seg_total, seg_id); end
    handshake();
  endtask

  task automatic test_saturation();
    logic [63:0] vec [4][4];
    logic [63:0] exp_total [4];
    vec[0] = '{ONES, ONES, ONES, ONES};                                exp_total[0] = ONES;
    vec[1] = '{ONES, 64'd1, 64'd0, 64'd0};                             exp_total[1] = ONES;
    vec[2] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFE, 64'd0, 64'd0};
    exp_total[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    vec[3] = '{ONES, ONES, ONES, 64'd3};                               exp_total[3] = ONES;
    for (int i = 0; i < 4; i++) begin
      start_move(8'(8'h40 + i));
      finish_max(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
      n_eval++; if (seg_total !== exp_total[i]) begin n_fail++; $display("FAIL sat_total[%0d]: got %h want %h", i, seg_total, exp_total[i]); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    start_move(8'h77);
    finish_max(1, 1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      n_eval++; if (seg_valid !== 1'b1 || cmd_ready !== 1'b0 || seg_total !== 64'd4 || seg_id !== 8'h77 || seg_timing[2] !== 64'd1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid %b ready %b total %0d id %h want 1 0 4 77", i, seg_valid, cmd_ready, seg_total, seg_id);
      end
      cmd_valid = 1'b1; cmd_id = 8'h99; max_finish = 1'b1; set_timing(ONES, 9, 9, 9);
      tick();
    end
    cmd_valid = 1'b0; max_finish = 1'b0;
    n_eval++; if (seg_valid !== 1'b1 || seg_total !== 64'd4) begin n_fail++; $display("FAIL bp_before_hs: valid %b total %0d want 1 4", seg_valid, seg_total); end
    handshake();
    n_eval++; if (seg_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_hs: valid %b ready %b want 0 1", seg_valid, cmd_ready); end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_id = 8'h01; tick();
    cmd_valid = 1'b0; tick();
    calc_done = 4'b1111; tick();
    calc_done = 4'b0000; tick();
    max_finish = 1'b1; set_timing(1, 0, 0, 0); tick();
    max_finish = 1'b0;
    n_eval++; if (seg_valid !== 1'b1 || seg_id !== 8'h01) begin n_fail++; $display("FAIL b2b_seg1: valid %b id %h want 1 01", seg_valid, seg_id); end
    handshake();
    n_eval++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_c6: got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_id = 8'h02; tick();
    cmd_valid = 1'b0;
    n_eval++; if ({calc_start, busy, seg_valid} !== 3'b110) begin n_fail++; $display("FAIL b2b_second_cmd: start/busy/valid %b want 110", {calc_start, busy, seg_valid}); end
    tick();
    calc_done = 4'b1111; tick();
    calc_done = 4'b0000;
    finish_max(2, 0, 0, 0);
    n_eval++; if (seg_total !== 64'd2 || seg_id !== 8'h02) begin n_fail++; $display("FAIL b2b_seg2: total %0d id %h want 2 02", seg_total, seg_id); end
    handshake();
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_id = 8'h33; tick();
    cmd_valid = 1'b0; tick();
    calc_done = 4'b0111; tick();
    calc_done = 4'b0000;
`ifdef SCHED_TIMEOUT_EN
    repeat (13) tick();
    n_eval++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_before: busy %b err %b want 1 0", busy, timeout_err); end
    tick();
    n_eval++; if ({timeout_err, busy, cmd_ready, seg_valid} !== 4'b1010) begin n_fail++; $display("FAIL to_expired: err/busy/ready/valid %b want 1010", {timeout_err, busy, cmd_ready, seg_valid}); end
    tick(); tick();
    n_eval++; if (seg_valid !== 1'b0 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: valid %b err %b want 0 1", seg_valid, timeout_err); end
    cmd_valid = 1'b1; cmd_id = 8'h34; tick();
    cmd_valid = 1'b0;
    n_eval++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_cleared: err %b want 0", timeout_err); end
    tick();
    calc_done = 4'b1111; tick();
    calc_done = 4'b0000;
    finish_max(3, 3, 3, 3);
    handshake();
`else
    repeat (40) tick();
    n_eval++; if ({busy, timeout_err, max_start, seg_valid} !== 4'b1000) begin n_fail++; $display("FAIL wait_unbounded: busy/err/max_start/valid %b want 1000", {busy, timeout_err, max_start, seg_valid}); end
    calc_done = 4'b1000; tick();
    calc_done = 4'b0000;
    n_eval++; if (max_start !== 1'b1) begin n_fail++; $display("FAIL wait_late_done: max_start %b want 1", max_start); end
    finish_max(3, 3, 3, 3);
    n_eval++; if (seg_total !== 64'd12 || seg_id !== 8'h33) begin n_fail++; $display("FAIL wait_seg: total %0d id %h want 12 33", seg_total, seg_id); end
    handshake();
`endif
  endtask

  task automatic test_reset_mid();
    start_move(8'h66);
    tick();
    #2 reset = 1'b0;
    #1;
    n_eval++; if ({cmd_ready, calc_start, max_start, seg_valid, busy, timeout_err} !== 6'b0) begin n_fail++; $display("FAIL rmid_ctrl: got %b want 000000", {cmd_ready, calc_start, max_start, seg_valid, busy, timeout_err}); end
    n_eval++; if (seg_total !== 64'd0 || seg_id !== '0) begin n_fail++; $display("FAIL rmid_data: total %h id %h want 0 0", seg_total, seg_id); end
    tick(); tick();
    reset = 1'b1;
    max_finish = 1'b1; set_timing(9, 9, 9, 9); tick();
    max_finish = 1'b0;
    n_eval++; if ({cmd_ready, busy, seg_valid} !== 3'b100) begin n_fail++; $display("FAIL rmid_release: ready/busy/valid %b want 100", {cmd_ready, busy, seg_valid}); end
    tick();
    n_eval++; if (seg_valid !== 1'b0 || seg_total !== 64'd0) begin n_fail++; $display("FAIL rmid_no_seg: valid %b total %0d want 0 0", seg_valid, seg_total); end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish within time limit");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_basic_flow();
    test_stale_done();
    test_ignored_inputs();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
